regfile_param: RTL and testbench

//  Parametrised general/temporary register file; successor to the fixed 4R+4T 8-bit file.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_cell.sv | 35 +++
 rtl/regfile_param.sv | 67 ++++++
 tb/tb_regfile_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings for the parametrised register file.
// FunSel codes plus the select-map origin of each register bank.
package regfile_pkg;

  typedef enum logic [1:0] {
    FUN_CLR = 2'b00,
    FUN_LD  = 2'b01,
    FUN_DEC = 2'b10,
    FUN_INC = 2'b11
  } fun_e;

  // Select codes start with the temporaries, then the general registers.
  localparam int T_BASE = 0;

  function automatic int r_base(input int num_t);
    return num_t;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register of the file: clear/load/dec/inc under an enable.
// wrap is combinational and flags an enabled inc/dec that rolls over this edge.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       fun,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      case (fun_e'(fun))
        FUN_CLR: q <= '0;
        FUN_LD:  q <= d;
        FUN_DEC: q <= q - ONE;
        default: q <= q + ONE;
      endcase
    end
  end

  assign wrap = en && (((fun == FUN_DEC) && (q == '0)) ||
                       ((fun == FUN_INC) && (q == '1)));

endmodule

// File: rtl/regfile_param.sv
// Parametrised T/R register file with two combinational read ports, a Zero
// vector and a registered Wrap flag. Define REGFILE_BYPASS_EN for load write-through.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NUM_R   = 4,
  parameter  int NUM_T   = 4,
  localparam int NUM_REG = NUM_T + NUM_R,
  localparam int SEL_W   = $clog2(NUM_REG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   I,
  input  logic [SEL_W-1:0]   O1Sel,
  input  logic [SEL_W-1:0]   O2Sel,
  input  logic [1:0]         FunSel,
  input  logic [NUM_R-1:0]   RSel,
  input  logic [NUM_T-1:0]   TSel,
  output logic [WIDTH-1:0]   O1,
  output logic [WIDTH-1:0]   O2,
  output logic [NUM_REG-1:0] Zero,
  output logic               Wrap
);

  logic [NUM_REG-1:0] en;
  logic [NUM_REG-1:0] cell_wrap;
  logic [WIDTH-1:0]   rq [NUM_REG];

  // Enable vector is laid out in select-code order: temporaries first.
  assign en[T_BASE +: NUM_T]        = TSel;
  assign en[r_base(NUM_T) +: NUM_R] = RSel;

  for (genvar k = 0; k < NUM_REG; k++) begin : g_cell
    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en[k]),
      .fun  (FunSel),
      .d    (I),
      .q    (rq[k]),
      .wrap (cell_wrap[k])
    );
    assign Zero[k] = (rq[k] == '0);
  end

  always_comb begin
    O1 = '0;
    O2 = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      if (O1Sel == k[SEL_W-1:0]) O1 = rq[k];
      if (O2Sel == k[SEL_W-1:0]) O2 = rq[k];
    end
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NUM_REG; k++) begin
      if ((FunSel == FUN_LD) && en[k] && (O1Sel == k[SEL_W-1:0])) O1 = I;
      if ((FunSel == FUN_LD) && en[k] && (O2Sel == k[SEL_W-1:0])) O2 = I;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Wrap <= 1'b0;
    else        Wrap <= |cell_wrap;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 8-bit 4T+4R instance plus a
// 16-bit 8T+8R instance for the wide wrap case.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_d;
  logic [2:0] o1sel, o2sel;
  logic [1:0] funsel;
  logic [3:0] rsel, tsel;
  logic [7:0] o1, o2, zero;
  logic       wrap;

  logic [15:0] b_i;
  logic [3:0]  b_o1sel, b_o2sel;
  logic [1:0]  b_fun;
  logic [7:0]  b_rsel, b_tsel;
  logic [15:0] b_o1, b_o2, b_zero;
  logic        b_wrap;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .I(i_d), .O1Sel(o1sel), .O2Sel(o2sel),
    .FunSel(funsel), .RSel(rsel), .TSel(tsel),
    .O1(o1), .O2(o2), .Zero(zero), .Wrap(wrap)
  );

  regfile_param #(.WIDTH(16), .NUM_R(8), .NUM_T(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .I(b_i), .O1Sel(b_o1sel), .O2Sel(b_o2sel),
    .FunSel(b_fun), .RSel(b_rsel), .TSel(b_tsel),
    .O1(b_o1), .O2(b_o2), .Zero(b_zero), .Wrap(b_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    funsel = 2'b00; rsel = '0; tsel = '0;
  endtask

  initial begin
    rst_n = 1'b0; i_d = '0; o1sel = '0; o2sel = '0; idle();
    b_i = '0; b_o1sel = 4'd15; b_o2sel = 4'd0; b_fun = 2'b00; b_rsel = '0; b_tsel = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("por_o1", o1, 8'h00);
    chk("por_zero", zero, 8'hFF);
    chk("por_wrap", wrap, 1'b0);

    // load 0x18 into R3 and T1
    funsel = 2'b01; i_d = 8'h18; rsel = 4'b0100; tsel = 4'b0001;
    tick();
    idle(); o1sel = 3'd6; o2sel = 3'd0;
    #1;
    chk("ld_o1_r3", o1, 8'h18);
    chk("ld_o2_t1", o2, 8'h18);
    chk("ld_zero", zero, 8'hBE);
    chk("ld_wrap", wrap, 1'b0);

    // dec then inc twice
    funsel = 2'b10; rsel = 4'b0100; tsel = 4'b0001;
    tick();
    idle(); #1;
    chk("dec_o1", o1, 8'h17);
    chk("dec_o2", o2, 8'h17);
    chk("dec_wrap", wrap, 1'b0);
    funsel = 2'b11; rsel = 4'b0100; tsel = 4'b0001;
    tick(); tick();
    idle(); #1;
    chk("inc2_o1", o1, 8'h19);
    chk("inc2_o2", o2, 8'h19);

    // R2 clear, dec underflow, inc overflow, load
    o1sel = 3'd5;
    funsel = 2'b00; rsel = 4'b0010;
    tick();
    chk("clr_wrap", wrap, 1'b0);
    funsel = 2'b10;
    tick();
    chk("uflow_val", o1, 8'hFF);
    chk("uflow_wrap", wrap, 1'b1);
    idle();
    tick();
    chk("wrap_pulse", wrap, 1'b0);
    funsel = 2'b11; rsel = 4'b0010;
    tick();
    chk("oflow_val", o1, 8'h00);
    chk("oflow_wrap", wrap, 1'b1);
    funsel = 2'b01; i_d = 8'h33;
    tick();
    chk("ld_clears_wrap", wrap, 1'b0);
    chk("ld_r2", o1, 8'h33);
    // dec with no enables must not flag a wrap even though T2 is zero
    funsel = 2'b10; rsel = '0; tsel = '0;
    tick();
    chk("noen_wrap", wrap, 1'b0);

    // load T2 with read port on it, pre-edge visibility depends on bypass
    o1sel = 3'd1; o2sel = 3'd1;
    funsel = 2'b01; i_d = 8'h5E; tsel = 4'b0010; rsel = '0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("pre_edge_o1", o1, 8'h5E);
    chk("pre_edge_o2", o2, 8'h5E);
`else
    chk("pre_edge_o1", o1, 8'h00);
    chk("pre_edge_o2", o2, 8'h00);
`endif
    tick();
    idle(); #1;
    chk("post_edge_o1", o1, 8'h5E);
    o1sel = 3'd7; o2sel = 3'd7;
    funsel = 2'b01; i_d = 8'hA5; rsel = 4'b1000;
    tick();
    idle(); #1;
    chk("r4_o1", o1, 8'hA5);
    chk("r4_o2", o2, 8'hA5);
    chk("zero_mix", zero, 8'h1C);

    // wide instance: R8 inc from FFFF
    b_fun = 2'b01; b_i = 16'hFFFF; b_rsel = 8'h80;
    tick();
    chk("w16_ld", b_o1, 16'hFFFF);
    chk("w16_ld_wrap", b_wrap, 1'b0);
    b_fun = 2'b11;
    tick();
    chk("w16_inc", b_o1, 16'h0000);
    chk("w16_wrap", b_wrap, 1'b1);
    chk("w16_zero", b_zero, 16'hFFFF);
    b_rsel = '0;
    tick();
    chk("w16_wrap_pulse", b_wrap, 1'b0);

    // async reset mid-run with a wrap pending on the output
    o1sel = 3'd6; o2sel = 3'd0;
    funsel = 2'b01; i_d = 8'hFF; rsel = 4'b1000;
    tick();
    funsel = 2'b11;
    tick();
    idle();
    chk("pre_rst_wrap", wrap, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o1", o1, 8'h00);
    chk("rst_o2", o2, 8'h00);
    chk("rst_zero", zero, 8'hFF);
    chk("rst_wrap", wrap, 1'b0);
    funsel = 2'b01; i_d = 8'h42; rsel = 4'b0100;
    #3 rst_n = 1'b1;
    tick();
    idle(); #1;
    chk("post_rst_ld", o1, 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
